// File: rtl/branch_pred_ctrl_if.sv
// Bundle between the pipeline and the branch-prediction controller.
// Handshake: i_ex_valid qualifies every i_ex_* field for the current cycle;
// there is no ready, the controller accepts a valid EX report every cycle.
// The IF lookup is unqualified and answered combinationally.
interface branch_pred_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  i_if_pc;
    logic             o_pred_taken;
    logic [PC_W-1:0]  o_pred_target;
    logic [1:0]       o_pc_sel;
    logic [PC_W-1:0]  o_redirect_pc;
    logic             o_flush;
    logic             i_ex_valid;
    logic             i_ex_is_branch;
    logic [PC_W-1:0]  i_ex_pc;
    logic             i_ex_taken;
    logic [PC_W-1:0]  i_ex_target;
    logic             i_ex_pred_taken;
    logic [PC_W-1:0]  i_ex_pred_target;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_miss_cnt;

    // Pipeline side
    modport master (
        output i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_taken,
               i_ex_target, i_ex_pred_taken, i_ex_pred_target,
        input  o_pred_taken, o_pred_target, o_pc_sel, o_redirect_pc,
               o_flush, o_br_cnt, o_miss_cnt
    );

    // Controller side
    modport slave (
        input  i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_taken,
               i_ex_target, i_ex_pred_taken, i_ex_pred_target,
        output o_pred_taken, o_pred_target, o_pc_sel, o_redirect_pc,
               o_flush, o_br_cnt, o_miss_cnt
    );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Bimodal branch predictor: 2-bit counter table plus BTB, PC mux select,
// mispredict detection/redirect and resolved/mispredict counters.
module branch_pred_ctrl #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    branch_pred_ctrl_if.slave  bp
);
    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             valid_q  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [PC_W-1:0]  target_q [N];
    logic [1:0]       ctr_q    [N];
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             mispredict;
    logic             ex_branch;
    logic             ex_clear;

    // Word-aligned PCs: the low two bits never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, bp.i_if_pc[1:0], bp.i_ex_pc[1:0]};

    // Index/tag split and table hits for both the IF and EX ports
    always_comb begin
        if_idx     = bp.i_if_pc[IDX_W+1:2];
        if_tag     = bp.i_if_pc[PC_W-1:IDX_W+2];
        ex_idx     = bp.i_ex_pc[IDX_W+1:2];
        ex_tag     = bp.i_ex_pc[PC_W-1:IDX_W+2];
        if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ex_branch  = bp.i_ex_valid && bp.i_ex_is_branch;
        ex_clear   = bp.i_ex_valid && !bp.i_ex_is_branch && bp.i_ex_pred_taken;
        mispredict = 1'b0;
        if (bp.i_ex_valid) begin
            if (bp.i_ex_is_branch) begin
                mispredict = (bp.i_ex_taken != bp.i_ex_pred_taken) ||
                             (bp.i_ex_taken && bp.i_ex_pred_taken &&
                              (bp.i_ex_pred_target != bp.i_ex_target));
            end else begin
                mispredict = bp.i_ex_pred_taken;
            end
        end
    end

    // Prediction, PC select and redirect; everything is held at zero in reset
    always_comb begin
        bp.o_pred_taken  = 1'b0;
        bp.o_pred_target = '0;
        bp.o_pc_sel      = 2'b00;
        bp.o_redirect_pc = '0;
        bp.o_flush       = 1'b0;
        if (!i_rst) begin
            bp.o_pred_taken  = if_hit && ctr_q[if_idx][1];
            bp.o_pred_target = bp.o_pred_taken ? target_q[if_idx] : '0;
            if (mispredict) begin
                bp.o_flush       = 1'b1;
                bp.o_pc_sel      = 2'b10;
                bp.o_redirect_pc = (bp.i_ex_is_branch && bp.i_ex_taken) ?
                                   bp.i_ex_target : bp.i_ex_pc + PC_W'(4);
            end else if (bp.o_pred_taken) begin
                bp.o_pc_sel = 2'b01;
            end
        end
    end

    assign bp.o_br_cnt   = br_cnt_q;
    assign bp.o_miss_cnt = miss_cnt_q;

    // Table training from EX outcomes; IF reads the pre-write contents
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ex_branch) begin
            if (ex_hit) begin
                if (bp.i_ex_taken) begin
                    target_q[ex_idx] <= bp.i_ex_target;
                    if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
                end else begin
                    if (ctr_q[ex_idx] != 2'b00) ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
                end
            end else if (bp.i_ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= bp.i_ex_target;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end else if (ex_clear && ex_hit) begin
            // A non-branch was predicted taken: drop the stale BTB entry
            valid_q[ex_idx] <= 1'b0;
        end
    end

    // Saturating performance counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (ex_branch && (br_cnt_q != '1))    br_cnt_q   <= br_cnt_q + CNT_W'(1);
            if (mispredict && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end
endmodule
